// File: rtl/capture_trigger.sv
// Decimated probe sampler with masked level/edge trigger; emits post_count samples as a data/strobe stream.
// Output registers: probe_i reaches data_o/strob_o two edges after sampling; done_o follows the last strobe by one edge.
module capture_trigger #(
   parameter int DATA_LEN = 8,
   parameter int CNT_LEN  = 16,
   parameter int DIV_LEN  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_LEN-1:0] probe_i,
   input  logic                arm_i,
   input  logic                abort_i,
   input  logic [DATA_LEN-1:0] trig_mask_i,
   input  logic [DATA_LEN-1:0] trig_value_i,
   input  logic                trig_edge_i,
   input  logic [DIV_LEN-1:0]  decim_i,
   input  logic [CNT_LEN-1:0]  post_count_i,
   output logic [DATA_LEN-1:0] data_o,
   output logic                strob_o,
   output logic                busy_o,
   output logic                triggered_o,
   output logic                done_o
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARMED   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_FINISH  = 2'd3;

   logic [1:0]          state_q,  state_d;
   logic [DATA_LEN-1:0] probe_q,  probe_d;
   logic [DATA_LEN-1:0] mask_q,   mask_d;
   logic [DATA_LEN-1:0] value_q,  value_d;
   logic                edge_q,   edge_d;
   logic [DIV_LEN-1:0]  decim_q,  decim_d;
   logic [CNT_LEN-1:0]  post_q,   post_d;
   logic [DIV_LEN-1:0]  div_q,    div_d;
   logic                prev_q,   prev_d;
   logic [CNT_LEN-1:0]  remain_q, remain_d;
   logic [DATA_LEN-1:0] data_q,   data_d;
   logic                strob_q,  strob_d;
   logic                done_q,   done_d;

   logic active;
   logic tick;
   logic match;
   logic trig;

   assign active = (state_q == S_ARMED) || (state_q == S_CAPTURE);
   assign tick   = active && (div_q == '0);
   assign match  = ((probe_q ^ value_q) & mask_q) == '0;
   assign trig   = edge_q ? (match & ~prev_q) : match;

   always_comb begin
      state_d  = state_q;
      probe_d  = probe_i;
      mask_d   = mask_q;
      value_d  = value_q;
      edge_d   = edge_q;
      decim_d  = decim_q;
      post_d   = post_q;
      div_d    = div_q;
      prev_d   = prev_q;
      remain_d = remain_q;
      data_d   = data_q;
      strob_d  = 1'b0;
      done_d   = 1'b0;

      if (active) begin
         div_d = (div_q == '0) ? decim_q : div_q - DIV_LEN'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (arm_i) begin
               mask_d  = trig_mask_i;
               value_d = trig_value_i;
               edge_d  = trig_edge_i;
               decim_d = decim_i;
               post_d  = (post_count_i == '0) ? CNT_LEN'(1) : post_count_i;
               div_d   = '0;
               prev_d  = 1'b1;
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (tick) begin
               prev_d = match;
               if (trig) begin
                  // The trigger sample itself counts as the first emitted sample.
                  data_d   = probe_q;
                  strob_d  = 1'b1;
                  remain_d = post_q - CNT_LEN'(1);
                  state_d  = (post_q <= CNT_LEN'(1)) ? S_FINISH : S_CAPTURE;
               end
            end
         end
         S_CAPTURE: begin
            if (tick) begin
               data_d   = probe_q;
               strob_d  = 1'b1;
               remain_d = (remain_q == '0) ? '0 : remain_q - CNT_LEN'(1);
               if (remain_q <= CNT_LEN'(1)) begin
                  state_d = S_FINISH;
               end
            end
         end
         default: begin
            // One extra busy cycle so done_o and the busy/triggered fall share an edge.
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
      endcase

      if (abort_i) begin
         state_d = S_IDLE;
         strob_d = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         probe_q  <= '0;
         mask_q   <= '0;
         value_q  <= '0;
         edge_q   <= 1'b0;
         decim_q  <= '0;
         post_q   <= '0;
         div_q    <= '0;
         prev_q   <= 1'b1;
         remain_q <= '0;
         data_q   <= '0;
         strob_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         probe_q  <= probe_d;
         mask_q   <= mask_d;
         value_q  <= value_d;
         edge_q   <= edge_d;
         decim_q  <= decim_d;
         post_q   <= post_d;
         div_q    <= div_d;
         prev_q   <= prev_d;
         remain_q <= remain_d;
         data_q   <= data_d;
         strob_q  <= strob_d;
         done_q   <= done_d;
      end
   end

   assign data_o      = data_q;
   assign strob_o     = strob_q;
   assign done_o      = done_q;
   assign busy_o      = (state_q != S_IDLE);
   assign triggered_o = (state_q == S_CAPTURE) || (state_q == S_FINISH);

endmodule

// File: tb/tb_capture_trigger.sv
// Bench for capture_trigger: event-list reference model derived from the trigger/decimation rules.
module tb_capture_trigger;

   localparam int MAXN = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  probe_i;
   logic        arm_i;
   logic        abort_i;
   logic [7:0]  trig_mask_i;
   logic [7:0]  trig_value_i;
   logic        trig_edge_i;
   logic [7:0]  decim_i;
   logic [15:0] post_count_i;
   logic [7:0]  data_o;
   logic        strob_o;
   logic        busy_o;
   logic        triggered_o;
   logic        done_o;

   int n_checks = 0;
   int n_errors = 0;

   int pin    [MAXN];
   int e_strob[MAXN];
   int e_data [MAXN];
   int e_busy [MAXN];
   int e_trig [MAXN];
   int e_done [MAXN];

   int obs_nstrobe, obs_first_k, obs_last_k, obs_first_data, obs_last_data, obs_ndone, obs_done_k;

   capture_trigger #(.DATA_LEN(8), .CNT_LEN(16), .DIV_LEN(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .probe_i      (probe_i),
      .arm_i        (arm_i),
      .abort_i      (abort_i),
      .trig_mask_i  (trig_mask_i),
      .trig_value_i (trig_value_i),
      .trig_edge_i  (trig_edge_i),
      .decim_i      (decim_i),
      .post_count_i (post_count_i),
      .data_o       (data_o),
      .strob_o      (strob_o),
      .busy_o       (busy_o),
      .triggered_o  (triggered_o),
      .done_o       (done_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Expected outputs after each edge k. A decision registered at edge e sees probe_i from edge e-1.
   task automatic model(input int mask, input int value, input int edg, input int decim,
                        input int post, input int n, input int arm_at, input int stop);
      int p, trig_e, last_e, cnt, prev, m, hit, hi;
      p      = (post == 0) ? 1 : post;
      trig_e = -1;
      last_e = -1;
      cnt    = 0;
      prev   = 1;
      for (int k = 0; k < MAXN; k++) begin
         e_strob[k] = 0; e_data[k] = 0; e_busy[k] = 0; e_trig[k] = 0; e_done[k] = 0;
      end
      for (int e = arm_at + 1; e < n; e += decim + 1) begin
         m = (((pin[e-1] ^ value) & mask) == 0) ? 1 : 0;
         if (trig_e < 0) begin
            hit  = (edg != 0) ? (m & ~prev & 1) : m;
            prev = m;
            if (hit != 0) trig_e = e;
         end
         if (trig_e >= 0) begin
            e_strob[e] = 1;
            e_data[e]  = pin[e-1];
            cnt++;
            if (cnt == p) begin
               last_e = e;
               break;
            end
         end
      end
      hi = (last_e >= 0) ? last_e : n - 1;
      for (int k = arm_at; k <= hi && k < n; k++) e_busy[k] = 1;
      if (trig_e >= 0)
         for (int k = trig_e; k <= hi && k < n; k++) e_trig[k] = 1;
      if (last_e >= 0 && last_e + 1 < n) e_done[last_e + 1] = 1;
      for (int k = stop; k < n; k++) begin
         e_strob[k] = 0; e_data[k] = 0; e_busy[k] = 0; e_trig[k] = 0; e_done[k] = 0;
      end
   endtask

   task automatic run(input int mask, input int value, input int edg, input int decim,
                      input int post, input int n, input int arm_at, input int abort_at,
                      input int rst_at, input bit extra_arms);
      int stop;
      bit arm_now;
      stop = n;
      if (abort_at >= 0 && abort_at < stop) stop = abort_at;
      if (rst_at >= 0 && rst_at < stop) stop = rst_at;
      model(mask, value, edg, decim, post, n, arm_at, stop);
      obs_nstrobe = 0; obs_first_k = -1; obs_last_k = -1;
      obs_first_data = -1; obs_last_data = -1; obs_ndone = 0; obs_done_k = -1;
      for (int k = 0; k < n; k++) begin
         arm_now = (k == arm_at) || (k == rst_at) ||
                   (extra_arms && k > arm_at && k < stop && e_busy[k-1] != 0 && $urandom_range(0, 5) == 0);
         if (k == arm_at) begin
            trig_mask_i  = 8'(mask);
            trig_value_i = 8'(value);
            trig_edge_i  = (edg != 0);
            decim_i      = 8'(decim);
            post_count_i = 16'(post);
         end else begin
            trig_mask_i  = 8'($urandom);
            trig_value_i = 8'($urandom);
            trig_edge_i  = 1'($urandom);
            decim_i      = 8'($urandom);
            post_count_i = 16'($urandom);
         end
         arm_i   = arm_now;
         probe_i = 8'(pin[k]);
         abort_i = (k == abort_at);
         rst     = (k == rst_at);
         @(posedge clk);
         #1;
         chk($sformatf("strob@%0d", k), int'(strob_o), e_strob[k]);
         chk($sformatf("busy@%0d", k), int'(busy_o), e_busy[k]);
         chk($sformatf("trig@%0d", k), int'(triggered_o), e_trig[k]);
         chk($sformatf("done@%0d", k), int'(done_o), e_done[k]);
         if (e_strob[k] != 0) chk($sformatf("data@%0d", k), int'(data_o), e_data[k]);
         if (k == rst_at) chk("rst_data", int'(data_o), 0);
         if (strob_o) begin
            if (obs_first_k < 0) begin
               obs_first_k    = k;
               obs_first_data = int'(data_o);
            end
            obs_last_k    = k;
            obs_last_data = int'(data_o);
            obs_nstrobe++;
         end
         if (done_o) begin
            obs_ndone++;
            obs_done_k = k;
         end
      end
      arm_i   = 1'b0;
      abort_i = 1'b0;
      rst     = 1'b0;
   endtask

   initial begin
      rst = 1'b1; arm_i = 1'b0; abort_i = 1'b0; probe_i = 8'h00;
      trig_mask_i = 8'h00; trig_value_i = 8'h00; trig_edge_i = 1'b0;
      decim_i = 8'h00; post_count_i = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data", int'(data_o), 0);
      chk("reset_strob", int'(strob_o), 0);
      chk("reset_busy", int'(busy_o), 0);
      chk("reset_trig", int'(triggered_o), 0);
      chk("reset_done", int'(done_o), 0);
      rst = 1'b0;

      // Level trigger on a ramp.
      for (int k = 0; k < MAXN; k++) pin[k] = k & 255;
      run(8'hFF, 8'hA5, 0, 0, 4, 200, 1, 199, -1, 1'b1);
      chk("lvl_nstrobe", obs_nstrobe, 4);
      chk("lvl_first", obs_first_data, 8'hA5);
      chk("lvl_last", obs_last_data, 8'hA8);
      chk("lvl_first_k", obs_first_k, 166);
      chk("lvl_done_k", obs_done_k, 170);

      // Edge trigger: bit0 high at arm, low 5 cycles, then high.
      for (int k = 0; k < MAXN; k++)
         pin[k] = ($urandom_range(0, 255) & 8'hFE) | ((k <= 5 || k >= 11) ? 1 : 0);
      run(8'h01, 8'h01, 1, 0, 2, 40, 2, 39, -1, 1'b0);
      chk("edge_first_k", obs_first_k, 12);
      chk("edge_nstrobe", obs_nstrobe, 2);

      // Decimation.
      for (int k = 0; k < MAXN; k++) pin[k] = $urandom_range(0, 255);
      run(0, 0, 0, 3, 3, 30, 1, 29, -1, 1'b0);
      chk("dec_nstrobe", obs_nstrobe, 3);
      chk("dec_first_k", obs_first_k, 2);
      chk("dec_span", obs_last_k - obs_first_k, 8);
      chk("dec_done_k", obs_done_k, 11);

      // post_count 0 and 1 both yield exactly one sample.
      for (int pc = 0; pc < 2; pc++) begin
         run(0, 0, 0, 1, pc, 20, 1, 19, -1, 1'b1);
         chk($sformatf("post%0d_nstrobe", pc), obs_nstrobe, 1);
         chk($sformatf("post%0d_ndone", pc), obs_ndone, 1);
      end

      // Abort after 10 strobes, then re-arm.
      run(0, 0, 0, 0, 100, 30, 1, 12, -1, 1'b0);
      chk("abort_nstrobe", obs_nstrobe, 10);
      chk("abort_ndone", obs_ndone, 0);
      run(0, 0, 0, 0, 5, 20, 1, 19, -1, 1'b0);
      chk("rearm_nstrobe", obs_nstrobe, 5);
      chk("rearm_ndone", obs_ndone, 1);

      // rst with arm while ARMED (edge mode, mask 0), then arm on the very next cycle.
      run(0, 0, 1, 0, 3, 11, 2, -1, 10, 1'b0);
      chk("edge0_nstrobe", obs_nstrobe, 0);
      run(0, 0, 0, 0, 2, 12, 0, 11, -1, 1'b0);
      chk("after_rst_nstrobe", obs_nstrobe, 2);
      run(0, 0, 1, 2, 3, 60, 1, 59, -1, 1'b0);
      chk("edge0_long_nstrobe", obs_nstrobe, 0);

      // Randomized runs.
      for (int r = 0; r < 40; r++) begin
         int ab;
         for (int k = 0; k < MAXN; k++) pin[k] = $urandom_range(0, 255);
         ab = ($urandom_range(0, 2) == 0) ? $urandom_range(8, 118) : 119;
         run($urandom_range(0, 255) & $urandom_range(0, 255) & $urandom_range(0, 255),
             $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 4),
             $urandom_range(0, 6), 120, $urandom_range(1, 5), ab, -1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
